// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory/I-O bus arbiter: command
// encodings, I/O address map and the transaction FSM state type.
package mem_bus_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner pick; purely combinational, the last-grant
// pointer lives in the parent.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port RAM and the LED/switch I/O between the CPU and
// the loader/DMA, one latched transaction at a time.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int              DW       = 16,
    parameter int              AW       = 9,
    parameter logic [AW-1:0]   LED_ADDR = mem_bus_pkg::LED_ADDR,
    parameter logic [AW-1:0]   SW_ADDR  = mem_bus_pkg::SW_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        cmd0,
    input  logic [1:0]        cmd1,
    input  logic [AW-1:0]     addr0,
    input  logic [AW-1:0]     addr1,
    input  logic [DW-1:0]     wdata0,
    input  logic [DW-1:0]     wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic [DW-1:0]     rdata,
    output logic [AW-2:0]     ram_addr,
    output logic              ram_write,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,
    input  logic [7:0]        sw,
    output logic [7:0]        led
);

    state_t          state_reg;
    logic            last_grant_reg;
    logic            winner_reg;
    logic [1:0]      cmd_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [1:0]      gnt_reg;
    logic [1:0]      ack_reg;
    logic            ram_write_reg;
    logic [DW-1:0]   rdata_reg;
    logic [7:0]      led_reg;

    logic [1:0]      req_eligible;
    logic            arb_valid;
    logic            arb_winner;
    logic [1:0]      arb_onehot;
    logic [1:0]      winner_onehot;
    logic [1:0]      sel_cmd;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW-1:0]   read_value;

    // The ack lands in the first IDLE cycle while the requester still holds
    // req; masking the just-acked requester keeps it from being served twice.
    assign req_eligible = req & ~ack_reg;

    rr_arbiter2 u_rr_arbiter2 (
        .req        (req_eligible),
        .last_grant (last_grant_reg),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_onehot
            assign arb_onehot[gi]    = (arb_winner == 1'(gi));
            assign winner_onehot[gi] = (winner_reg == 1'(gi));
        end
    endgenerate

    assign sel_cmd   = arb_winner ? cmd1   : cmd0;
    assign sel_addr  = arb_winner ? addr1  : addr0;
    assign sel_wdata = arb_winner ? wdata1 : wdata0;

    always_comb begin
        read_value = '0;
        if (!addr_reg[AW-1]) begin
            read_value = ram_dout;
        end else if (addr_reg == SW_ADDR) begin
            read_value = {{(DW-8){1'b0}}, sw};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            winner_reg     <= 1'b0;
            cmd_reg        <= MEM_NONE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            gnt_reg        <= '0;
            ack_reg        <= '0;
            ram_write_reg  <= 1'b0;
            rdata_reg      <= '0;
            led_reg        <= '0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (arb_valid) begin
                        winner_reg    <= arb_winner;
                        cmd_reg       <= sel_cmd;
                        addr_reg      <= sel_addr;
                        wdata_reg     <= sel_wdata;
                        gnt_reg       <= arb_onehot;
                        ram_write_reg <= (sel_cmd == MEM_WRITE) && !sel_addr[AW-1];
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_write_reg <= 1'b0;
                    if (cmd_reg == MEM_WRITE && addr_reg == LED_ADDR) begin
                        led_reg <= wdata_reg[7:0];
                    end
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cmd_reg == MEM_READ) begin
                        rdata_reg <= read_value;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    ack_reg        <= winner_onehot;
                    last_grant_reg <= winner_reg;
                    gnt_reg        <= '0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign ack       = ack_reg;
    assign rdata     = rdata_reg;
    assign ram_addr  = addr_reg[AW-2:0];
    assign ram_write = ram_write_reg;
    assign ram_din   = wdata_reg;
    assign led       = led_reg;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port 256x16 RAM and the memory-mapped I/O (LED register, switch input) between two bus masters.
- Requester 0 is the CPU; requester 1 is the program loader/debug DMA.
- Each requester owns a request/ack handshake. The block latches one transaction at a time, sequences it against the RAM's registered read, and decodes I/O addresses.
- Sits between the masters and RAM in the top level, replacing the ad-hoc combinational decode.

Parameters:
- DW, 16, data width.
- AW, 9, bus address width; bit 8 = 0 selects RAM.
- LED_ADDR, 9'h100, LED register address (write only).
- SW_ADDR, 9'h140, switch input address (read only).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request; held until the matching ack.
- cmd0, cmd1  in  2 each  00 none, 01 read, 10 write, 11 reserved.
- addr0, addr1  in  9 each  bus address.
- wdata0, wdata1  in  16 each  write data.
- gnt  out  2  one-hot owner of the transaction in flight.
- ack  out  2  one-cycle completion pulse per requester.
- rdata  out  16  read result; valid when ack is high, held until the next completion.
- ram_addr  out  8  RAM address.
- ram_write  out  1  RAM write enable.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM registered read data; valid one cycle after the address is presented.
- sw  in  8  switch inputs.
- led  out  8  LED register.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; gnt, ack, ram_write = 0; rdata = 0; led = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - No req: stay.
  - Any req: pick a winner, latch its cmd/addr/wdata into internal registers, set gnt, go to ACCESS.
- Winner selection:
  - Only one requester active: it wins.
  - Both active: winner = ~last_grant (round-robin).
- ACCESS:
  - ram_addr = latched addr[7:0]; ram_din = latched wdata.
  - ram_write = 1 only if cmd = write and addr[8] = 0.
  - LED write (cmd = write and addr = LED_ADDR): led <= wdata[7:0] at the exiting edge.
  - Go to WAIT.
- WAIT:
  - ram_write = 0; ram_dout is valid.
  - At the exiting edge, rdata <= selected value, then go to DONE. Selection:
    - RAM read (addr[8] = 0): ram_dout.
    - Read of SW_ADDR: {8'h00, sw}.
    - Any other read: 16'h0000.
    - Write or none: rdata unchanged.
- DONE:
  - ack[winner] = 1 for exactly one cycle.
  - last_grant <= winner; gnt cleared at the exiting edge; go to IDLE.
- Timing and outputs:
  - ram_write, gnt and ack are decoded from registered state only; no combinational path from req to any output.
  - Latency: req sampled at edge E; ack high in the cycle after edge E+3.
  - Throughput: one transaction per 4 cycles minimum. req still high in DONE is re-evaluated in IDLE.
- Boundary cases:
  - cmd 00 or 11: treated as a no-op. Still acked; rdata unchanged; no RAM or LED effect.
  - Write to SW_ADDR or to an unmapped address with bit 8 = 1: ignored but acked.
  - Read of LED_ADDR returns 16'h0000.
  - Requester drops req mid-transaction: the transaction completes and ack is still pulsed. The requester's inputs may change after IDLE because everything is latched.
  - Reset mid-transaction: the transaction is abandoned with no ack. A RAM write in ACCESS is cut off asynchronously. A LED update occurs only if its edge completed before reset.

Decomposition:
- Shared package mem_bus_pkg holds:
  - command encodings MEM_NONE, MEM_READ, MEM_WRITE;
  - LED_ADDR and SW_ADDR constants;
  - FSM state enum.
- One sub-module, rr_arbiter2: a combinational winner pick from req and last_grant. The pointer register stays in the parent.

Test Plan:
- Reset: hold reset_n low mid-stream -> gnt = 00, ack = 00, ram_write = 0, led = 8'h00, rdata = 16'h0000, asynchronously.
- RAM round trip: req0 writes 16'hABCD to 9'h005, then reads 9'h005 -> ram_write high exactly one cycle with ram_addr 8'h05; read ack[0] 4 cycles after sampling with rdata = 16'hABCD.
- Contention: req = 11 continuously from reset -> grant order 0,1,0,1; ack pulses alternate; no overlapping gnt bits.
- I/O decode:
  - Write 16'h12A5 to 9'h100 -> led = 8'hA5, ram_write never high.
  - sw = 8'h3C, read 9'h140 -> rdata = 16'h003C.
- Unmapped and no-op:
  - Write to 9'h1FF -> acked, led and RAM unchanged.
  - Read 9'h1FF -> rdata = 16'h0000.
  - cmd 11 -> acked, rdata unchanged.
- Reset mid-write: assert reset_n low during ACCESS of a write -> ram_write falls immediately, no ack. The next write after reset completes normally with requester 0 winning a tie.
